casez_rr_arbiter: RTL

//  Round-robin arbiter sharing one resource (the casez/casex decode datapath) among 4 requesters.

---
 rtl/casez_rr_arbiter_if.sv | 15 +
 rtl/casez_rr_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/casez_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives requests; the slave (arbiter) side drives grants.
interface casez_rr_arbiter_if;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             timeout;

  modport master (output req, input gnt, gnt_id, gnt_vld, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_vld, timeout);
endinterface

// File: rtl/casez_rr_arbiter.sv
// Four-way round-robin arbiter for the shared decode datapath: casez priority on the
// rotated request vector, per-owner hold timeout, and re-arm masking of timed-out requesters.
module casez_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst_n,
  casez_rr_arbiter_if.slave bus
);
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   mask_q, mask_d;

  logic [N_REQ-1:0]   valid_req;
  logic [N_REQ-1:0]   eff_req;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    match_pos;
  logic               found;
  logic [ID_W-1:0]    winner;

  // Only a solid 1 is a request; X/Z on a line can never win a grant.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      valid_req[i] = (bus.req[i] === 1'b1);
    end
    eff_req = valid_req & ~mask_q;
  end

  // Rotate right by ptr, then lowest set bit of the rotated vector wins.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rot[j] = eff_req[ID_W'(j) + ptr_q];
    end
    found     = 1'b1;
    match_pos = '0;
    casez (rot)
      4'b???1: match_pos = 2'd0;
      4'b??10: match_pos = 2'd1;
      4'b?100: match_pos = 2'd2;
      4'b1000: match_pos = 2'd3;
      default: found = 1'b0;
    endcase
    winner = match_pos + ptr_q;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    mask_d     = mask_q & valid_req;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          gnt_d      = N_REQ'(1) << winner;
          gnt_id_d   = winner;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = CNT_W'(1);
        end
      end
      BUSY: begin
        if (!valid_req[gnt_id_q]) begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_vld_d  = 1'b0;
          ptr_d      = gnt_id_q + ID_W'(1);
          hold_cnt_d = '0;
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
          // Forced release: owner must drop req before it may win again.
          state_d          = GAP;
          gnt_d            = '0;
          gnt_vld_d        = 1'b0;
          timeout_d        = 1'b1;
          mask_d[gnt_id_q] = 1'b1;
          ptr_d            = gnt_id_q + ID_W'(1);
          hold_cnt_d       = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.timeout = timeout_q;
endmodule
